regs_ula_datapath: RTL and testbench
====================================

Name: regs_ula_datapath

Overview:
- Datapath stage directly downstream of the X/Y/Z/ULA control sequencer.
- Holds three working registers X, Y and Z plus an ALU (ULA), and executes one register-transfer step per clock under the tx/ty/tz/tula codes.
- X captures the external operand, Y accumulates ALU results, and Z captures the finished Y value.
- Z is the block's result, qualified by a one-cycle valid pulse.

Parameters:
- WIDTH, 8, data width of entrada, X, Y, Z and the ALU.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- entrada  input  WIDTH  external operand loaded into X.
- tx  input  5  X register op code: 0=CLEAR, 1=LOAD, 2=HOLD, 3=SHIFTL.
- ty  input  5  Y register op code, same encoding.
- tz  input  5  Z register op code, same encoding.
- tula  input  5  ALU op code: 0=ADD, 1=SUB, 2=AND, 3=OR.
- x_out  output  WIDTH  current X.
- y_out  output  WIDTH  current Y.
- z_out  output  WIDTH  current Z; block result.
- flag_carry  output  1  registered carry/borrow/shift-out of the last Y arithmetic or shift.
- flag_zero  output  1  combinational (y_out == 0).
- z_valid  output  1  high for exactly one cycle after Z loads.

Behaviour:
- Reset (async, active-high):
  - X, Y, Z = 0; flag_carry = 0; z_valid = 0.
  - flag_zero therefore reads 1.
  - Asserting reset mid-sequence discards all state with no partial update. The first posedge after deassertion uses the op codes present at that edge.
- Op codes:
  - Values 0..3 as listed under Ports.
  - Any op code value 4..31 on tx/ty/tz is treated as HOLD.
- All three registers update on the same edge. Every source is the pre-edge value (true register-transfer semantics, no bypass).
- X sources:
  - CLEAR -> 0.
  - LOAD -> entrada.
  - HOLD -> X.
  - SHIFTL -> {X[WIDTH-2:0],0}.
- Y sources:
  - CLEAR -> 0.
  - LOAD -> ULA(Y,X).
  - HOLD -> Y.
  - SHIFTL -> {Y[WIDTH-2:0],0}.
- Z sources:
  - CLEAR -> 0.
  - LOAD -> Y.
  - HOLD -> Z.
  - SHIFTL -> {Z[WIDTH-2:0],0}.
- ULA (combinational, operand order Y op X, WIDTH-bit result, WIDTH+1-bit internal sum):
  - ADD: Y+X; carry = bit WIDTH of the sum.
  - SUB: Y-X; carry = borrow (1 when X > Y unsigned).
  - AND / OR: bitwise; carry = 0.
  - tula 4..31: result = X, carry = 0.
- flag_carry:
  - Updated only when ty = LOAD (takes the ULA carry) or ty = SHIFTL (takes the old Y[WIDTH-1]).
  - Held otherwise, including when ty = CLEAR.
- z_valid:
  - Registered; set to 1 on any edge where tz = LOAD, otherwise 0.
  - It is thus high during the cycle z_out shows the newly loaded value.
  - Back-to-back LOADs keep z_valid high continuously.
- There are no illegal combinations: simultaneous CLEAR/LOAD/SHIFTL on different registers are independent.
- ty SHIFTL ignores tula.

Decomposition:
- Shared package regs_ula_pkg holds:
  - register op constants CLEAR=0, LOAD=1, HOLD=2, SHIFTL=3;
  - ALU op constants ULA_ADD=0, ULA_SUB=1, ULA_AND=2, ULA_OR=3;
  - op code width 5.
- The sequencer uses the same package.
- One natural sub-module: reg_op (WIDTH-parameterised register with clear/load/hold/shift-left, async reset, load-data input, shift-out output), instantiated for X, Y and Z.
- The ULA stays inline.

Test Plan (WIDTH=8):
- Full sequence, entrada=5, applying (tx,ty,tz,tula) = (1,0,0,0),(1,1,0,0),(1,1,0,0),(0,1,0,1),(0,3,0,0),(0,0,1,0) on successive edges:
  - expected (X,Y) after each edge: (5,0),(5,5),(5,10),(0,5),(0,10);
  - after the final edge Z=10, with z_valid=1 for that one cycle only.
- Add overflow: with Y=200, X=100, apply ty=LOAD, tula=ADD -> Y=44, flag_carry=1. Then an ADD with Y=1, X=2 -> Y=3, flag_carry=0.
- Subtract borrow: with Y=3, X=5, apply ty=LOAD, tula=SUB -> Y=254, flag_carry=1. Then ty=CLEAR -> Y=0, flag_zero=1, flag_carry still 1.
- Shift-out: with Y=0x81, apply ty=SHIFTL -> Y=0x02, flag_carry=1. With X=0xC0, apply tx=SHIFTL -> X=0x80.
- Undefined codes: tx=ty=tz=7 for 3 cycles -> X, Y, Z unchanged. With tula=9 and ty=LOAD -> Y=X, flag_carry=0.
- Async reset mid-op: assert reset between edges while X=5, Y=10 -> x_out, y_out, z_out immediately 0, z_valid 0, flag_zero 1, with no clock edge needed.

Source files
------------

// File: rtl/regs_ula_pkg.sv
// Shared op-code definitions for the X/Y/Z/ULA sequencer and datapath.
// Register op codes outside 0..3 decode to HOLD.
package regs_ula_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] CLEAR  = 5'd0;
  localparam logic [OP_W-1:0] LOAD   = 5'd1;
  localparam logic [OP_W-1:0] HOLD   = 5'd2;
  localparam logic [OP_W-1:0] SHIFTL = 5'd3;

  localparam logic [OP_W-1:0] ULA_ADD = 5'd0;
  localparam logic [OP_W-1:0] ULA_SUB = 5'd1;
  localparam logic [OP_W-1:0] ULA_AND = 5'd2;
  localparam logic [OP_W-1:0] ULA_OR  = 5'd3;

  typedef enum logic [1:0] {
    OP_CLEAR,
    OP_LOAD,
    OP_HOLD,
    OP_SHIFTL
  } reg_op_e;

  function automatic reg_op_e decode_op(input logic [OP_W-1:0] code);
    case (code)
      CLEAR:   return OP_CLEAR;
      LOAD:    return OP_LOAD;
      SHIFTL:  return OP_SHIFTL;
      default: return OP_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/regs_ula_datapath_reg_op.sv
// Working register with clear / load / hold / shift-left control.
// shift_out exposes the bit that a SHIFTL would push out.
module reg_op
  import regs_ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             shift_out
);

  reg_op_e op_dec;

  assign op_dec    = decode_op(op);
  assign shift_out = q[WIDTH-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (op_dec)
        OP_CLEAR:  q <= '0;
        OP_LOAD:   q <= load_data;
        OP_SHIFTL: q <= {q[WIDTH-2:0], 1'b0};
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/regs_ula_datapath.sv
// X/Y/Z register-transfer datapath with inline ULA; one transfer step per clock.
// All registers sample pre-edge values, so there is no bypass between them.
module regs_ula_datapath
  import regs_ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] entrada,
  input  logic [OP_W-1:0]  tx,
  input  logic [OP_W-1:0]  ty,
  input  logic [OP_W-1:0]  tz,
  input  logic [OP_W-1:0]  tula,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic             z_valid
);

  logic [WIDTH-1:0] ula_result;
  logic             ula_carry;
  logic [WIDTH:0]   ula_sum;
  logic [WIDTH:0]   ula_diff;
  logic             y_shift_out;
  logic             x_shift_unused;
  logic             z_shift_unused;
  reg_op_e          ty_dec;
  reg_op_e          tz_dec;

  assign ty_dec = decode_op(ty);
  assign tz_dec = decode_op(tz);

  reg_op #(.WIDTH(WIDTH)) u_x (
    .clock     (clock),
    .reset     (reset),
    .op        (tx),
    .load_data (entrada),
    .q         (x_out),
    .shift_out (x_shift_unused)
  );

  reg_op #(.WIDTH(WIDTH)) u_y (
    .clock     (clock),
    .reset     (reset),
    .op        (ty),
    .load_data (ula_result),
    .q         (y_out),
    .shift_out (y_shift_out)
  );

  reg_op #(.WIDTH(WIDTH)) u_z (
    .clock     (clock),
    .reset     (reset),
    .op        (tz),
    .load_data (y_out),
    .q         (z_out),
    .shift_out (z_shift_unused)
  );

  // The extra top bit of the subtraction is the borrow (set when X > Y).
  assign ula_sum  = {1'b0, y_out} + {1'b0, x_out};
  assign ula_diff = {1'b0, y_out} - {1'b0, x_out};

  always_comb begin
    ula_result = x_out;
    ula_carry  = 1'b0;
    case (tula)
      ULA_ADD: begin
        ula_result = ula_sum[WIDTH-1:0];
        ula_carry  = ula_sum[WIDTH];
      end
      ULA_SUB: begin
        ula_result = ula_diff[WIDTH-1:0];
        ula_carry  = ula_diff[WIDTH];
      end
      ULA_AND: ula_result = y_out & x_out;
      ULA_OR:  ula_result = y_out | x_out;
      default: ula_result = x_out;
    endcase
  end

  // Carry only tracks Y arithmetic and shifts; a CLEAR of Y leaves it alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_carry <= 1'b0;
      z_valid    <= 1'b0;
    end else begin
      if (ty_dec == OP_LOAD) begin
        flag_carry <= ula_carry;
      end else if (ty_dec == OP_SHIFTL) begin
        flag_carry <= y_shift_out;
      end
      z_valid <= (tz_dec == OP_LOAD);
    end
  end

  assign flag_zero = (y_out == '0);

endmodule

// File: tb/tb_regs_ula_datapath.sv
// Table-driven bench for regs_ula_datapath with a scoreboard queue of expected states.
// Hand-written sequences cover reset state and asynchronous reset mid-operation.
module tb_regs_ula_datapath;

  typedef struct {
    logic [4:0] tx, ty, tz, tula;
    logic [7:0] entrada;
    logic [7:0] ex, ey, ez;
    logic       ec, ev;
  } vec_t;

  typedef struct {
    logic [7:0] x, y, z;
    logic       c, zf, v;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [7:0] entrada;
  logic [4:0] tx, ty, tz, tula;
  logic [7:0] x_out, y_out, z_out;
  logic       flag_carry, flag_zero, z_valid;

  int tests;
  int failures;

  vec_t vecs[$];
  exp_t scoreboard[$];

  regs_ula_datapath #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .entrada    (entrada),
    .tx         (tx),
    .ty         (ty),
    .tz         (tz),
    .tula       (tula),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .z_valid    (z_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [4:0] a, b, c, d, input logic [7:0] e,
                              input logic [7:0] x, y, z, input logic cy, v);
    vec_t r;
    r.tx = a; r.ty = b; r.tz = c; r.tula = d; r.entrada = e;
    r.ex = x; r.ey = y; r.ez = z; r.ec = cy; r.ev = v;
    return r;
  endfunction

  function automatic exp_t mkexp(input logic [7:0] x, y, z, input logic c, v);
    exp_t r;
    r.x = x; r.y = y; r.z = z; r.c = c; r.v = v;
    r.zf = (y == 8'd0);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t vec);
    @(negedge clock);
    tx = vec.tx; ty = vec.ty; tz = vec.tz; tula = vec.tula; entrada = vec.entrada;
    scoreboard.push_back(mkexp(vec.ex, vec.ey, vec.ez, vec.ec, vec.ev));
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (scoreboard.size() == 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e = scoreboard.pop_front();
    tests++;
    if (x_out !== e.x || y_out !== e.y || z_out !== e.z ||
        flag_carry !== e.c || flag_zero !== e.zf || z_valid !== e.v) begin
      failures++;
      $display("[TB] FAIL %s: got x=%h y=%h z=%h c=%b zf=%b v=%b, want x=%h y=%h z=%h c=%b zf=%b v=%b",
               name, x_out, y_out, z_out, flag_carry, flag_zero, z_valid,
               e.x, e.y, e.z, e.c, e.zf, e.v);
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    reset = 1'b1;
    entrada = 8'h00;
    tx = 5'd2; ty = 5'd2; tz = 5'd2; tula = 5'd0;

    // Worked sequence, overflow, borrow, shifts, undefined codes, Z ops, logic ops.
    vecs.push_back(mk(1, 0, 0, 0, 8'd5,   8'd5,   8'd0,   8'd0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'd5,   8'd5,   8'd5,   8'd0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'd5,   8'd5,   8'd10,  8'd0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'hAA,  8'd0,   8'd5,   8'd0,  0, 0));
    vecs.push_back(mk(0, 3, 0, 0, 8'hAA,  8'd0,   8'd10,  8'd0,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'hAA,  8'd0,   8'd0,   8'd10, 0, 1));
    vecs.push_back(mk(2, 2, 2, 0, 8'hAA,  8'd0,   8'd0,   8'd10, 0, 0));
    vecs.push_back(mk(1, 0, 2, 0, 8'd200, 8'd200, 8'd0,   8'd10, 0, 0));
    vecs.push_back(mk(1, 1, 2, 0, 8'd100, 8'd100, 8'd200, 8'd10, 0, 0));
    vecs.push_back(mk(2, 1, 2, 0, 8'hAA,  8'd100, 8'd44,  8'd10, 1, 0));
    vecs.push_back(mk(1, 0, 2, 0, 8'd1,   8'd1,   8'd0,   8'd10, 1, 0));
    vecs.push_back(mk(1, 1, 2, 0, 8'd2,   8'd2,   8'd1,   8'd10, 0, 0));
    vecs.push_back(mk(2, 1, 2, 0, 8'hAA,  8'd2,   8'd3,   8'd10, 0, 0));
    vecs.push_back(mk(1, 2, 2, 0, 8'd5,   8'd5,   8'd3,   8'd10, 0, 0));
    vecs.push_back(mk(2, 1, 2, 1, 8'hAA,  8'd5,   8'd254, 8'd10, 1, 0));
    vecs.push_back(mk(2, 0, 2, 0, 8'hAA,  8'd5,   8'd0,   8'd10, 1, 0));
    vecs.push_back(mk(1, 2, 2, 0, 8'h81,  8'h81,  8'd0,   8'd10, 1, 0));
    vecs.push_back(mk(1, 1, 2, 0, 8'hC0,  8'hC0,  8'h81,  8'd10, 0, 0));
    vecs.push_back(mk(3, 3, 2, 5, 8'hAA,  8'h80,  8'h02,  8'd10, 1, 0));
    vecs.push_back(mk(7, 7, 7, 0, 8'hAA,  8'h80,  8'h02,  8'd10, 1, 0));
    vecs.push_back(mk(7, 7, 7, 0, 8'hAA,  8'h80,  8'h02,  8'd10, 1, 0));
    vecs.push_back(mk(7, 7, 7, 0, 8'hAA,  8'h80,  8'h02,  8'd10, 1, 0));
    vecs.push_back(mk(2, 1, 2, 9, 8'hAA,  8'h80,  8'h80,  8'd10, 0, 0));
    vecs.push_back(mk(2, 2, 3, 0, 8'hAA,  8'h80,  8'h80,  8'd20, 0, 0));
    vecs.push_back(mk(2, 2, 1, 0, 8'hAA,  8'h80,  8'h80,  8'h80, 0, 1));
    vecs.push_back(mk(2, 2, 1, 0, 8'hAA,  8'h80,  8'h80,  8'h80, 0, 1));
    vecs.push_back(mk(2, 2, 0, 0, 8'hAA,  8'h80,  8'h80,  8'd0,  0, 0));
    vecs.push_back(mk(1, 2, 2, 0, 8'h0F,  8'h0F,  8'h80,  8'd0,  0, 0));
    vecs.push_back(mk(2, 1, 2, 3, 8'hAA,  8'h0F,  8'h8F,  8'd0,  0, 0));
    vecs.push_back(mk(2, 1, 2, 2, 8'hAA,  8'h0F,  8'h0F,  8'd0,  0, 0));
    vecs.push_back(mk(1, 0, 2, 0, 8'd5,   8'd5,   8'd0,   8'd0,  0, 0));
    vecs.push_back(mk(2, 1, 2, 0, 8'hAA,  8'd5,   8'd5,   8'd0,  0, 0));
    vecs.push_back(mk(2, 1, 2, 0, 8'hAA,  8'd5,   8'd10,  8'd0,  0, 0));
    vecs.push_back(mk(2, 2, 1, 0, 8'hAA,  8'd5,   8'd10,  8'd10, 0, 1));

    repeat (2) @(posedge clock);
    #1;
    scoreboard.push_back(mkexp(8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
    checkOutput("reset_state");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges must clear state without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    scoreboard.push_back(mkexp(8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
    checkOutput("async_reset");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(mk(1, 1, 0, 0, 8'd5, 8'd5, 8'd0, 8'd0, 0, 0));
    checkOutput("post_reset_edge");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
